// File: rtl/aig_tt_scanner_if.sv
// Handshake, stimulus/response and truth-table read bus of the AIG truth-table scanner.
// slave = scanner side, master = controller/DUT-harness side.
interface aig_tt_scanner_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 19,
    parameter int SIG_W = 32
);
    logic             start;
    logic             busy;
    logic             done;
    logic [N_IN-1:0]  vec_out;
    logic [N_OUT-1:0] resp_in;
    logic [SIG_W-1:0] sig;
    logic             rd_en;
    logic [N_IN-1:0]  rd_addr;
    logic [N_OUT-1:0] rd_data;

    modport master (
        output start, resp_in, rd_en, rd_addr,
        input  busy, done, vec_out, sig, rd_data
    );

    modport slave (
        input  start, resp_in, rd_en, rd_addr,
        output busy, done, vec_out, sig, rd_data
    );
endinterface

// File: rtl/aig_tt_scanner.sv
// Exhaustive input sweep of a combinational AIG with truth-table capture and MISR signature.
// Optional per-output ones counters are enabled with `define TT_POPCNT_EN.
module aig_tt_scanner #(
    parameter int               N_IN   = 4,
    parameter int               N_OUT  = 19,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = 32'h0040_0007,
    parameter logic [SIG_W-1:0] SEED   = 32'hFFFF_FFFF,
    parameter int               SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    aig_tt_scanner_if.slave bus
`ifdef TT_POPCNT_EN
    ,
    input  logic [$clog2(N_OUT > 1 ? N_OUT : 2)-1:0] pc_sel,
    output logic [N_IN:0]                             ones_cnt
`endif
);
    localparam int              DEPTH    = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_OUT-1:0] rd_q;
    logic [SIG_W-1:0] misr_next;

    logic [N_OUT-1:0] tt_mem [DEPTH];

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(bus.resp_in);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    sig_d   = SEED;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_C;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) state_d = SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SAMPLE: begin
                sig_d = misr_next;
                // Terminal compare happens before increment so the vector never wraps.
                if (vec_q == LAST_VEC) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_C;
                    state_d = DRIVE;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Truth-table storage carries no reset; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == SAMPLE) tt_mem[vec_q] <= bus.resp_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         rd_q <= '0;
        else if (bus.rd_en) rd_q <= tt_mem[bus.rd_addr];
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.vec_out = vec_q;
    assign bus.sig     = sig_q;
    assign bus.rd_data = rd_q;

`ifdef TT_POPCNT_EN
    logic [N_OUT-1:0][N_IN:0] pc_q;
    logic                     pc_clr;

    assign pc_clr = (state_q == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (!rst_n || pc_clr) begin
            pc_q <= '0;
        end else if (state_q == SAMPLE) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (bus.resp_in[i]) pc_q[i] <= pc_q[i] + 1'b1;
            end
        end
    end

    assign ones_cnt = (int'(pc_sel) < N_OUT) ? pc_q[pc_sel] : '0;
`endif
endmodule

// File: tb/tb_aig_tt_scanner.sv
// Randomized self-checking bench for aig_tt_scanner against a truth-table/MISR reference model.
// u0: default parameters with selectable response stub; u1: SETTLE=3, SEED=0, responses tied to 0.
module tb_aig_tt_scanner;
    localparam logic [31:0] POLY = 32'h0040_0007;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          total = 0;
    int          bad   = 0;
    int          mode  = 0;
    logic [18:0] tt [16];

    aig_tt_scanner_if #(.N_IN(4), .N_OUT(19), .SIG_W(32)) b0 ();
    aig_tt_scanner_if #(.N_IN(4), .N_OUT(19), .SIG_W(32)) b1 ();

`ifdef TT_POPCNT_EN
    logic [4:0] pc_sel0, pc_sel1;
    logic [4:0] ones0, ones1;
`endif

    aig_tt_scanner u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
`ifdef TT_POPCNT_EN
        , .pc_sel(pc_sel0), .ones_cnt(ones0)
`endif
    );

    aig_tt_scanner #(.SETTLE(3), .SEED(32'h0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef TT_POPCNT_EN
        , .pc_sel(pc_sel1), .ones_cnt(ones1)
`endif
    );

    always_comb begin
        b0.resp_in = '0;
        case (mode)
            0:       b0.resp_in = 19'(b0.vec_out);
            1:       b0.resp_in = tt[b0.vec_out];
            default: b0.resp_in = {17'd0, &b0.vec_out, b0.vec_out[0]};
        endcase
    end

    assign b1.resp_in = '0;
    assign b1.rd_en   = 1'b0;
    assign b1.rd_addr = '0;

    function automatic logic [18:0] resp_ref(int m, int v);
        logic [3:0] vv;
        vv = v[3:0];
        case (m)
            0:       return 19'(vv);
            1:       return tt[vv];
            default: return {17'd0, &vv, vv[0]};
        endcase
    endfunction

    function automatic logic [31:0] sig_ref(logic [31:0] seed, int m);
        logic [31:0] s;
        s = seed;
        for (int v = 0; v < 16; v++)
            s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ {13'd0, resp_ref(m, v)};
        return s;
    endfunction

    // Called right after the accept edge; lat = edges from accept to the edge that samples done=1.
    task automatic wait_done0(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (b0.done) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic run0(output int lat);
        @(negedge clk) b0.start = 1'b1;
        @(posedge clk);
        #1 b0.start = 1'b0;
        wait_done0(lat);
    endtask

    task automatic read0(input int a, output logic [18:0] d);
        @(negedge clk);
        b0.rd_en   = 1'b1;
        b0.rd_addr = a[3:0];
        @(posedge clk);
        #1 b0.rd_en = 1'b0;
        d = b0.rd_data;
    endtask

    task automatic test_reset();
        int lat;
        mode = 0;
        b0.start = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", b0.busy); end
        total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", b0.done); end
        total++; if (b0.vec_out !== 4'd0) begin bad++; $display("FAIL rst_vec got=%0h exp=0", b0.vec_out); end
        total++; if (b0.sig !== 32'd0) begin bad++; $display("FAIL rst_sig got=%0h exp=0", b0.sig); end
        total++; if (b0.rd_data !== 19'd0) begin bad++; $display("FAIL rst_rd_data got=%0h exp=0", b0.rd_data); end
        total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL rst_busy_u1 got=%0h exp=0", b1.busy); end
        rst_n = 1'b1;
        @(posedge clk);
        #1 b0.start = 1'b0;
        total++; if (b0.busy !== 1'b1) begin bad++; $display("FAIL rst_release_accept got=%0h exp=1", b0.busy); end
        wait_done0(lat);
        total++; if (lat !== 49) begin bad++; $display("FAIL rst_sweep_latency got=%0d exp=49", lat); end
        @(negedge clk);
        total++; if (b0.sig !== sig_ref(32'hFFFF_FFFF, 0)) begin bad++; $display("FAIL rst_sweep_sig got=%0h exp=%0h", b0.sig, sig_ref(32'hFFFF_FFFF, 0)); end
    endtask

    task automatic test_loopback();
        int          lat;
        logic [18:0] d;
        mode = 0;
        run0(lat);
        total++; if (lat !== 49) begin bad++; $display("FAIL loop_latency got=%0d exp=49", lat); end
        @(negedge clk);
        total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL loop_done_pulse got=%0h exp=0", b0.done); end
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL loop_busy_end got=%0h exp=0", b0.busy); end
        total++; if (b0.vec_out !== 4'hF) begin bad++; $display("FAIL loop_vec_hold got=%0h exp=f", b0.vec_out); end
        total++; if (b0.sig !== sig_ref(32'hFFFF_FFFF, 0)) begin bad++; $display("FAIL loop_sig got=%0h exp=%0h", b0.sig, sig_ref(32'hFFFF_FFFF, 0)); end
        for (int a = 0; a < 16; a++) begin
            read0(a, d);
            total++; if (d !== resp_ref(0, a)) begin bad++; $display("FAIL loop_read[%0d] got=%0h exp=%0h", a, d, resp_ref(0, a)); end
        end
        @(negedge clk) b0.rd_addr = 4'd3;
        @(posedge clk);
        #1;
        total++; if (b0.rd_data !== 19'd15) begin bad++; $display("FAIL loop_rd_hold got=%0h exp=f", b0.rd_data); end
    endtask

    task automatic test_random();
        int          lat;
        int          a;
        logic [18:0] d;
        for (int it = 0; it < 3; it++) begin
            for (int v = 0; v < 16; v++) tt[v] = 19'($urandom);
            mode = 1;
            run0(lat);
            total++; if (lat !== 49) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=49", it, lat); end
            @(negedge clk);
            total++; if (b0.sig !== sig_ref(32'hFFFF_FFFF, 1)) begin bad++; $display("FAIL rand_sig[%0d] got=%0h exp=%0h", it, b0.sig, sig_ref(32'hFFFF_FFFF, 1)); end
            for (int r = 0; r < 6; r++) begin
                a = int'($urandom_range(0, 15));
                read0(a, d);
                total++; if (d !== tt[a]) begin bad++; $display("FAIL rand_read[%0d] got=%0h exp=%0h", a, d, tt[a]); end
            end
        end
    endtask

    task automatic test_settle3();
        int dones = 0;
        int lat   = -1;
        @(negedge clk) b1.start = 1'b1;
        @(posedge clk);
        #1 b1.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b1.done) begin
                dones++;
                if (lat < 0) lat = k + 1;
            end
            if (k < 80) begin
                total++; if (b1.vec_out !== 4'(k / 5)) begin bad++; $display("FAIL s3_vec[k=%0d] got=%0h exp=%0h", k, b1.vec_out, k / 5); end
            end
            total++; if (b1.busy !== (k <= 80)) begin bad++; $display("FAIL s3_busy[k=%0d] got=%0h exp=%0h", k, b1.busy, k <= 80); end
            total++; if (b1.sig !== 32'd0) begin bad++; $display("FAIL s3_sig[k=%0d] got=%0h exp=0", k, b1.sig); end
            b1.start = (k == 10 || k == 40);
        end
        b1.start = 1'b0;
        total++; if (lat !== 81) begin bad++; $display("FAIL s3_latency got=%0d exp=81", lat); end
        total++; if (dones !== 1) begin bad++; $display("FAIL s3_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_midreset();
        int          lat;
        int          dones = 0;
        int          a;
        logic [18:0] d;
        for (int v = 0; v < 16; v++) tt[v] = 19'($urandom);
        mode = 1;
        @(negedge clk) b0.start = 1'b1;
        @(posedge clk);
        #1 b0.start = 1'b0;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0h exp=0", b0.busy); end
        total++; if (b0.vec_out !== 4'd0) begin bad++; $display("FAIL mid_vec got=%0h exp=0", b0.vec_out); end
        total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0h exp=0", b0.done); end
        total++; if (b0.sig !== 32'd0) begin bad++; $display("FAIL mid_sig got=%0h exp=0", b0.sig); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b0.done || b0.busy) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL mid_no_activity got=%0d exp=0", dones); end
        run0(lat);
        total++; if (lat !== 49) begin bad++; $display("FAIL mid_restart_latency got=%0d exp=49", lat); end
        @(negedge clk);
        total++; if (b0.sig !== sig_ref(32'hFFFF_FFFF, 1)) begin bad++; $display("FAIL mid_restart_sig got=%0h exp=%0h", b0.sig, sig_ref(32'hFFFF_FFFF, 1)); end
        for (int r = 0; r < 4; r++) begin
            a = int'($urandom_range(0, 15));
            read0(a, d);
            total++; if (d !== tt[a]) begin bad++; $display("FAIL mid_read[%0d] got=%0h exp=%0h", a, d, tt[a]); end
        end
    endtask

`ifdef TT_POPCNT_EN
    task automatic test_popcnt();
        int          lat;
        int          exp_cnt;
        logic [18:0] r;
        int          sels [4] = '{0, 1, 2, 19};
        mode = 2;
        run0(lat);
        total++; if (lat !== 49) begin bad++; $display("FAIL pc_latency got=%0d exp=49", lat); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_cnt = 0;
            if (sels[i] < 19) begin
                for (int v = 0; v < 16; v++) begin
                    r = resp_ref(2, v);
                    if (r[sels[i]]) exp_cnt++;
                end
            end
            pc_sel0 = 5'(sels[i]);
            #1;
            total++; if (ones0 !== 5'(exp_cnt)) begin bad++; $display("FAIL pc_cnt[sel=%0d] got=%0d exp=%0d", sels[i], ones0, exp_cnt); end
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        b0.start   = 1'b0;
        b0.rd_en   = 1'b0;
        b0.rd_addr = '0;
        b1.start   = 1'b0;
`ifdef TT_POPCNT_EN
        pc_sel0 = '0;
        pc_sel1 = '0;
`endif
        test_reset();
        test_loopback();
        test_random();
        test_settle3();
        test_midreset();
`ifdef TT_POPCNT_EN
        test_popcnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
